// File: rtl/iob_fifo_sync_asym.sv
// +----------------------------------------------------------------------------+
// | Module   : iob_fifo_sync_asym                                              |
// | Purpose  : Single-clock FIFO controller with independent write/read widths |
// |            driving an external asymmetric RAM, with level and status flags.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module iob_fifo_sync_asym #(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 4,
  localparam int MINDATA_W = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W,
  localparam int MAXDATA_W = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W,
  localparam int RATIO     = MAXDATA_W / MINDATA_W,
  localparam int DIFF      = $clog2(RATIO),
  localparam int W_ADDR_W  = (W_DATA_W > R_DATA_W) ? ADDR_W - DIFF : ADDR_W,
  localparam int R_ADDR_W  = (R_DATA_W > W_DATA_W) ? ADDR_W - DIFF : ADDR_W
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                ce_i,
  input  logic                rst_i,
  input  logic                w_en_i,
  input  logic [W_DATA_W-1:0] w_data_i,
  output logic                w_full_o,
  input  logic                r_en_i,
  output logic [R_DATA_W-1:0] r_data_o,
  output logic                r_valid_o,
  output logic                r_empty_o,
  output logic [ADDR_W:0]     level_o,
  input  logic [ADDR_W:0]     af_thresh_i,
  input  logic [ADDR_W:0]     ae_thresh_i,
  output logic                almost_full_o,
  output logic                almost_empty_o,
  output logic                overflow_o,
  output logic                underflow_o,
  output logic                ext_mem_w_en_o,
  output logic [W_ADDR_W-1:0] ext_mem_w_addr_o,
  output logic [W_DATA_W-1:0] ext_mem_w_data_o,
  output logic                ext_mem_r_en_o,
  output logic [R_ADDR_W-1:0] ext_mem_r_addr_o,
  input  logic [R_DATA_W-1:0] ext_mem_r_data_i
);

  localparam int FIFO_SIZE = 2 ** ADDR_W;
  localparam int W_INCR    = (W_DATA_W > R_DATA_W) ? RATIO : 1;
  localparam int R_INCR    = (R_DATA_W > W_DATA_W) ? RATIO : 1;

  // Level and increments are all expressed in narrow-word units.
  localparam logic [ADDR_W:0]   C_W_INCR     = (ADDR_W+1)'(W_INCR);
  localparam logic [ADDR_W:0]   C_R_INCR     = (ADDR_W+1)'(R_INCR);
  localparam logic [ADDR_W:0]   C_FULL_LIMIT = (ADDR_W+1)'(FIFO_SIZE - W_INCR);
  localparam logic [W_ADDR_W:0] C_WPTR_ONE   = (W_ADDR_W+1)'(1);
  localparam logic [R_ADDR_W:0] C_RPTR_ONE   = (R_ADDR_W+1)'(1);

  logic [W_ADDR_W:0] r_waddr;
  logic [R_ADDR_W:0] r_raddr;
  logic [ADDR_W:0]   r_level;
  logic              r_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [ADDR_W:0]   w_wr_step;
  logic [ADDR_W:0]   w_rd_step;
  logic [ADDR_W:0]   w_level_nxt;

  // Flags come from the registered level only: no same-cycle bypass.
  assign w_full_o  = (r_level > C_FULL_LIMIT);
  assign r_empty_o = (r_level < C_R_INCR);

  assign w_wr_acc  = ce_i & w_en_i & ~w_full_o;
  assign w_rd_acc  = ce_i & r_en_i & ~r_empty_o;

  assign w_wr_step   = w_wr_acc ? C_W_INCR : '0;
  assign w_rd_step   = w_rd_acc ? C_R_INCR : '0;
  assign w_level_nxt = r_level + w_wr_step - w_rd_step;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_waddr     <= '0;
      r_raddr     <= '0;
      r_level     <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (rst_i) begin
      r_waddr     <= '0;
      r_raddr     <= '0;
      r_level     <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (ce_i) begin
      if (w_wr_acc) begin
        r_waddr <= r_waddr + C_WPTR_ONE;
      end
      if (w_rd_acc) begin
        r_raddr <= r_raddr + C_RPTR_ONE;
      end
      r_level <= w_level_nxt;
      r_valid <= w_rd_acc;
      if (w_en_i & w_full_o) begin
        r_overflow <= 1'b1;
      end
      if (r_en_i & r_empty_o) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign level_o        = r_level;
  assign r_valid_o      = r_valid;
  assign overflow_o     = r_overflow;
  assign underflow_o    = r_underflow;
  assign almost_full_o  = (r_level >= af_thresh_i);
  assign almost_empty_o = (r_level <= ae_thresh_i);
  assign r_data_o       = ext_mem_r_data_i;

  assign ext_mem_w_en_o   = w_wr_acc;
  assign ext_mem_w_addr_o = r_waddr[W_ADDR_W-1:0];
  assign ext_mem_w_data_o = w_data_i;
  assign ext_mem_r_en_o   = w_rd_acc;
  assign ext_mem_r_addr_o = r_raddr[R_ADDR_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_iob_fifo_sync_asym.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_iob_fifo_sync_asym                                           |
// | Purpose  : Directed bench for three width configurations with RAM models.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_iob_fifo_sync_asym;

  logic clk;
  logic arst_n;
  logic ce;
  logic rst;
  int   total;
  int   bad;

  // instance A: 32-bit write, 8-bit read
  logic        w_en_a, r_en_a, full_a, empty_a, valid_a, af_a, ae_a, ovf_a, unf_a;
  logic [31:0] w_data_a;
  logic [7:0]  r_data_a;
  logic [4:0]  level_a;
  logic        mw_en_a, mr_en_a;
  logic [1:0]  mw_addr_a;
  logic [3:0]  mr_addr_a;
  logic [31:0] mw_data_a;
  logic [7:0]  mr_data_a;
  logic [7:0]  mem_a [0:15];

  // instance B: 8-bit write, 32-bit read
  logic        w_en_b, r_en_b, full_b, empty_b, valid_b, af_b, ae_b, ovf_b, unf_b;
  logic [7:0]  w_data_b;
  logic [31:0] r_data_b;
  logic [4:0]  level_b;
  logic        mw_en_b, mr_en_b;
  logic [3:0]  mw_addr_b;
  logic [1:0]  mr_addr_b;
  logic [7:0]  mw_data_b;
  logic [31:0] mr_data_b;
  logic [7:0]  mem_b [0:15];

  // instance C: symmetric 8-bit
  logic        w_en_c, r_en_c, full_c, empty_c, valid_c, af_c, ae_c, ovf_c, unf_c;
  logic [7:0]  w_data_c;
  logic [7:0]  r_data_c;
  logic [4:0]  level_c;
  logic        mw_en_c, mr_en_c;
  logic [3:0]  mw_addr_c, mr_addr_c;
  logic [7:0]  mw_data_c;
  logic [7:0]  mr_data_c;
  logic [7:0]  mem_c [0:15];

  iob_fifo_sync_asym #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) u_dut_a (
    .clk_i(clk), .arst_n_i(arst_n), .ce_i(ce), .rst_i(rst),
    .w_en_i(w_en_a), .w_data_i(w_data_a), .w_full_o(full_a),
    .r_en_i(r_en_a), .r_data_o(r_data_a), .r_valid_o(valid_a), .r_empty_o(empty_a),
    .level_o(level_a), .af_thresh_i(5'd16), .ae_thresh_i(5'd0),
    .almost_full_o(af_a), .almost_empty_o(ae_a), .overflow_o(ovf_a), .underflow_o(unf_a),
    .ext_mem_w_en_o(mw_en_a), .ext_mem_w_addr_o(mw_addr_a), .ext_mem_w_data_o(mw_data_a),
    .ext_mem_r_en_o(mr_en_a), .ext_mem_r_addr_o(mr_addr_a), .ext_mem_r_data_i(mr_data_a)
  );

  iob_fifo_sync_asym #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) u_dut_b (
    .clk_i(clk), .arst_n_i(arst_n), .ce_i(ce), .rst_i(rst),
    .w_en_i(w_en_b), .w_data_i(w_data_b), .w_full_o(full_b),
    .r_en_i(r_en_b), .r_data_o(r_data_b), .r_valid_o(valid_b), .r_empty_o(empty_b),
    .level_o(level_b), .af_thresh_i(5'd16), .ae_thresh_i(5'd0),
    .almost_full_o(af_b), .almost_empty_o(ae_b), .overflow_o(ovf_b), .underflow_o(unf_b),
    .ext_mem_w_en_o(mw_en_b), .ext_mem_w_addr_o(mw_addr_b), .ext_mem_w_data_o(mw_data_b),
    .ext_mem_r_en_o(mr_en_b), .ext_mem_r_addr_o(mr_addr_b), .ext_mem_r_data_i(mr_data_b)
  );

  iob_fifo_sync_asym #(.W_DATA_W(8), .R_DATA_W(8), .ADDR_W(4)) u_dut_c (
    .clk_i(clk), .arst_n_i(arst_n), .ce_i(ce), .rst_i(rst),
    .w_en_i(w_en_c), .w_data_i(w_data_c), .w_full_o(full_c),
    .r_en_i(r_en_c), .r_data_o(r_data_c), .r_valid_o(valid_c), .r_empty_o(empty_c),
    .level_o(level_c), .af_thresh_i(5'd14), .ae_thresh_i(5'd2),
    .almost_full_o(af_c), .almost_empty_o(ae_c), .overflow_o(ovf_c), .underflow_o(unf_c),
    .ext_mem_w_en_o(mw_en_c), .ext_mem_w_addr_o(mw_addr_c), .ext_mem_w_data_o(mw_data_c),
    .ext_mem_r_en_o(mr_en_c), .ext_mem_r_addr_o(mr_addr_c), .ext_mem_r_data_i(mr_data_c)
  );

  // Byte-addressed RAM models; a wide word covers consecutive bytes, LS byte lowest.
  always @(posedge clk) begin
    if (mw_en_a) begin
      for (int k = 0; k < 4; k++) mem_a[{mw_addr_a, 2'(k)}] <= mw_data_a[8*k +: 8];
    end
    if (mr_en_a) mr_data_a <= mem_a[mr_addr_a];
    if (mw_en_b) mem_b[mw_addr_b] <= mw_data_b;
    if (mr_en_b) mr_data_b <= {mem_b[{mr_addr_b, 2'd3}], mem_b[{mr_addr_b, 2'd2}],
                               mem_b[{mr_addr_b, 2'd1}], mem_b[{mr_addr_b, 2'd0}]};
    if (mw_en_c) mem_c[mw_addr_c] <= mw_data_c;
    if (mr_en_c) mr_data_c <= mem_c[mr_addr_c];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    arst_n = 1'b0; ce = 1'b1; rst = 1'b0;
    w_en_a = 0; r_en_a = 0; w_data_a = '0;
    w_en_b = 0; r_en_b = 0; w_data_b = '0;
    w_en_c = 0; r_en_c = 0; w_data_c = '0;
    #12;
    check("rst_level_a", 32'(level_a), 32'd0);
    check("rst_empty_a", 32'(empty_a), 32'd1);
    check("rst_full_a",  32'(full_a),  32'd0);
    check("rst_ae_a",    32'(ae_a),    32'd1);
    check("rst_valid_a", 32'(valid_a), 32'd0);
    check("rst_ovf_a",   32'(ovf_a),   32'd0);
    arst_n = 1'b1;
    tick();

    // A: one wide write, four narrow reads LS slice first
    w_en_a = 1; w_data_a = 32'h44332211;
    #1 check("a_wen_accept", 32'(mw_en_a), 32'd1);
    tick();
    w_en_a = 0;
    check("a_level_w1", 32'(level_a), 32'd4);
    check("a_empty_w1", 32'(empty_a), 32'd0);
    r_en_a = 1;
    tick(); check("a_rd0", 32'(r_data_a), 32'h11); check("a_v0", 32'(valid_a), 32'd1); check("a_l0", 32'(level_a), 32'd3);
    tick(); check("a_rd1", 32'(r_data_a), 32'h22); check("a_l1", 32'(level_a), 32'd2);
    tick(); check("a_rd2", 32'(r_data_a), 32'h33); check("a_l2", 32'(level_a), 32'd1);
    tick(); check("a_rd3", 32'(r_data_a), 32'h44); check("a_l3", 32'(level_a), 32'd0);
    check("a_empty_end", 32'(empty_a), 32'd1);
    r_en_a = 0;
    tick(); check("a_valid_drop", 32'(valid_a), 32'd0);

    // A: fill to full, then overflow
    w_en_a = 1;
    w_data_a = 32'hA0A0A0A0; tick();
    w_data_a = 32'hA1A1A1A1; tick();
    w_data_a = 32'hA2A2A2A2; tick();
    check("a_notfull_12", 32'(full_a), 32'd0);
    w_data_a = 32'hA3A3A3A3; tick();
    check("a_level_full", 32'(level_a), 32'd16);
    check("a_full", 32'(full_a), 32'd1);
    check("a_af", 32'(af_a), 32'd1);
    w_data_a = 32'hDEADBEEF;
    #1 check("a_wen_refused", 32'(mw_en_a), 32'd0);
    tick();
    w_en_a = 0;
    check("a_ovf", 32'(ovf_a), 32'd1);
    check("a_level_ovf", 32'(level_a), 32'd16);
    tick();
    check("a_ovf_sticky", 32'(ovf_a), 32'd1);

    // B: narrow writes pack into one wide read
    w_en_b = 1;
    w_data_b = 8'hA0; tick();
    w_data_b = 8'hB1; tick();
    w_data_b = 8'hC2; tick();
    check("b_empty_3", 32'(empty_b), 32'd1);
    check("b_level_3", 32'(level_b), 32'd3);
    w_data_b = 8'hD3; tick();
    w_en_b = 0;
    check("b_empty_4", 32'(empty_b), 32'd0);
    r_en_b = 1;
    tick();
    check("b_rd", r_data_b, 32'hD3C2B1A0);
    check("b_valid", 32'(valid_b), 32'd1);
    check("b_level_0", 32'(level_b), 32'd0);
    check("b_unf_pre", 32'(unf_b), 32'd0);
    tick();
    r_en_b = 0;
    check("b_unf", 32'(unf_b), 32'd1);
    check("b_valid_unf", 32'(valid_b), 32'd0);

    // C: fill 0..16 checking programmable flags
    for (int i = 0; i <= 16; i++) begin
      check($sformatf("c_fill_level%0d", i), 32'(level_c), 32'(i));
      check($sformatf("c_ae%0d", i), 32'(ae_c), (i <= 2) ? 32'd1 : 32'd0);
      check($sformatf("c_af%0d", i), 32'(af_c), (i >= 14) ? 32'd1 : 32'd0);
      if (i < 16) begin
        w_en_c = 1; w_data_c = 8'(i);
        tick();
        w_en_c = 0;
      end
    end
    check("c_full", 32'(full_c), 32'd1);
    r_en_c = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("c_drain%0d", k), 32'(r_data_c), 32'(k));
    end
    r_en_c = 0;
    check("c_level8", 32'(level_c), 32'd8);
    // simultaneous traffic across the address wrap
    w_en_c = 1; r_en_c = 1;
    for (int k = 0; k < 20; k++) begin
      w_data_c = 8'(16 + k);
      tick();
      check($sformatf("c_sim_data%0d", k), 32'(r_data_c), 32'(8 + k));
      check($sformatf("c_sim_level%0d", k), 32'(level_c), 32'd8);
    end
    r_en_c = 0;
    w_data_c = 8'h55;
    tick();
    w_en_c = 0;
    check("c_level9", 32'(level_c), 32'd9);

    // soft reset acts even with ce low
    ce = 0; rst = 1;
    tick();
    rst = 0; ce = 1;
    check("srst_level_c", 32'(level_c), 32'd0);
    check("srst_empty_c", 32'(empty_c), 32'd1);
    check("srst_valid_c", 32'(valid_c), 32'd0);
    check("srst_af_c",    32'(af_c),    32'd0);
    check("srst_ovf_a",   32'(ovf_a),   32'd0);
    check("srst_unf_b",   32'(unf_b),   32'd0);

    // asynchronous reset takes effect between edges
    w_en_c = 1;
    w_data_c = 8'h01; tick();
    w_data_c = 8'h02; tick();
    w_data_c = 8'h03; tick();
    w_en_c = 0;
    check("c_level3", 32'(level_c), 32'd3);
    #2 arst_n = 0;
    #1 check("arst_level_c", 32'(level_c), 32'd0);
    check("arst_empty_c", 32'(empty_c), 32'd1);
    tick();
    arst_n = 1;
    tick();

    // clock enable low freezes all state
    w_en_c = 1;
    w_data_c = 8'h0A; tick();
    w_data_c = 8'h0B; tick();
    w_data_c = 8'h0C; tick();
    w_en_c = 0; r_en_c = 1;
    tick();
    r_en_c = 0;
    check("ce_pre_data", 32'(r_data_c), 32'h0A);
    check("ce_pre_level", 32'(level_c), 32'd2);
    ce = 0; w_en_c = 1; w_data_c = 8'hEE;
    #1 check("ce_wen_gated", 32'(mw_en_c), 32'd0);
    tick(); tick(); tick();
    check("ce_level_frozen", 32'(level_c), 32'd2);
    check("ce_valid_frozen", 32'(valid_c), 32'd1);
    ce = 1; w_en_c = 0; r_en_c = 1;
    tick();
    r_en_c = 0;
    check("ce_resume_data", 32'(r_data_c), 32'h0B);
    check("ce_resume_level", 32'(level_c), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
